// File: rtl/rv32i_defs_pkg.sv
// Shared rv32i definitions used by the data-memory arbiter: arbitration FSM
// states, response owner encoding, the request bundle and starvation helper.
package rv32i_defs_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned MASK_W   = 3;
    localparam int unsigned STARVE_W = 4;

    // Which requester holds the memory port in the current cycle.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN_CPU = 2'd1,
        ST_OWN_DBG = 2'd2
    } arb_state_e;

    // Owner of an in-flight load response.
    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } owner_e;

    // One requester's view of a memory access.
    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [MASK_W-1:0] mask;
    } mem_req_t;

    // Next starvation count: clears when the debug port is not waiting,
    // otherwise counts up and holds at the limit.
    function automatic logic [STARVE_W-1:0] starve_next(
        input logic [STARVE_W-1:0] cnt,
        input logic [STARVE_W-1:0] limit,
        input logic                waiting
    );
        if (!waiting) begin
            return '0;
        end
        if (cnt >= limit) begin
            return limit;
        end
        return cnt + STARVE_W'(1);
    endfunction

endpackage

// File: rtl/dmem_rsp_tracker.sv
// Remembers which port issued the load in flight and routes the memory's
// one-cycle-late read data back to that port only.
module dmem_rsp_tracker
    import rv32i_defs_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_issue_i,
    input  owner_e          load_owner_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            cpu_rvalid_o,
    output logic [XLEN-1:0] cpu_rdata_o,
    output logic            dbg_rvalid_o,
    output logic [XLEN-1:0] dbg_rdata_o
);

    logic   resp_valid_q, resp_valid_d;
    owner_e resp_owner_q, resp_owner_d;

    assign resp_valid_d = load_issue_i;
    assign resp_owner_d = load_owner_i;

    // Capture the load issued this cycle; reset drops any pending response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            resp_valid_q <= 1'b0;
            resp_owner_q <= OWNER_CPU;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
        end
    end

    assign cpu_rvalid_o = resp_valid_q && (resp_owner_q == OWNER_CPU);
    assign dbg_rvalid_o = resp_valid_q && (resp_owner_q == OWNER_DBG);

    // The port that does not own the response sees zero data.
    assign cpu_rdata_o = cpu_rvalid_o ? mem_rdata_i : '0;
    assign dbg_rdata_o = dbg_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: the CPU wins by default, the debug port is
// force-granted after STARVE_LIMIT (1..15) consecutive stalled cycles. Grants
// are combinational; load data returns one cycle later to the issuing port.
module dmem_arbiter
    import rv32i_defs_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [XLEN-1:0]   cpu_addr_i,
    input  logic [XLEN-1:0]   cpu_wdata_i,
    input  logic [MASK_W-1:0] cpu_mask_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [XLEN-1:0]   cpu_rdata_o,

    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [XLEN-1:0]   dbg_addr_i,
    input  logic [XLEN-1:0]   dbg_wdata_i,
    input  logic [MASK_W-1:0] dbg_mask_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [XLEN-1:0]   dbg_rdata_o,

    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [MASK_W-1:0] mem_mask_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    arb_state_e          state_q, state_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                grant_en_q;

    logic     cpu_gnt, dbg_gnt, any_gnt;
    mem_req_t cpu_req_s, dbg_req_s, sel_req;
    owner_e   sel_owner;

    assign cpu_req_s = '{we: cpu_we_i, addr: cpu_addr_i, wdata: cpu_wdata_i, mask: cpu_mask_i};
    assign dbg_req_s = '{we: dbg_we_i, addr: dbg_addr_i, wdata: dbg_wdata_i, mask: dbg_mask_i};

    // Priority arbitration: debug wins only when the CPU is idle or debug has starved.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path holds a value and no latch is inferred.
        dbg_gnt = 1'b0;
        cpu_gnt = 1'b0;
        if (grant_en_q && dbg_req_i && (!cpu_req_i || (starve_cnt_q == LIMIT))) begin
            dbg_gnt = 1'b1;
        end
        if (grant_en_q && cpu_req_i && !dbg_gnt) begin
            cpu_gnt = 1'b1;
        end
    end

    assign any_gnt   = cpu_gnt | dbg_gnt;
    assign cpu_gnt_o = cpu_gnt;
    assign dbg_gnt_o = dbg_gnt;

    // Route the winning request onto the shared memory port; all-zero when idle.
    always_comb begin
        sel_req   = '0;
        sel_owner = OWNER_CPU;
        if (cpu_gnt) begin
            sel_req = cpu_req_s;
        end else if (dbg_gnt) begin
            sel_req   = dbg_req_s;
            sel_owner = OWNER_DBG;
        end
    end

    assign mem_addr_o  = sel_req.addr;
    assign mem_wdata_o = sel_req.wdata;
    assign mem_mask_o  = sel_req.mask;
    assign mem_re_o    = any_gnt & ~sel_req.we;
    assign mem_we_o    = any_gnt &  sel_req.we;

    // Next owner record and starvation count.
    always_comb begin
        state_d = ST_IDLE;
        if (cpu_gnt) begin
            state_d = ST_OWN_CPU;
        end else if (dbg_gnt) begin
            state_d = ST_OWN_DBG;
        end
        starve_cnt_d = starve_next(starve_cnt_q, LIMIT, dbg_req_i & ~dbg_gnt);
    end

    // Arbitration state; grants stay off until the first edge after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            grant_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            grant_en_q   <= 1'b1;
        end
    end

    dmem_rsp_tracker u_rsp_tracker (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_issue_i (mem_re_o),
        .load_owner_i (sel_owner),
        .mem_rdata_i  (mem_rdata_i),
        .cpu_rvalid_o (cpu_rvalid_o),
        .cpu_rdata_o  (cpu_rdata_o),
        .dbg_rvalid_o (dbg_rvalid_o),
        .dbg_rdata_o  (dbg_rdata_o)
    );

    // A response must return to the port the FSM recorded as owner last cycle.
    a_cpu_rsp_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cpu_rvalid_o |-> (state_q == ST_OWN_CPU));
    a_dbg_rsp_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        dbg_rvalid_o |-> (state_q == ST_OWN_DBG));
    a_one_grant: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(cpu_gnt && dbg_gnt));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a random
// phase, with load responses predicted into a scoreboard queue at issue time.
module tb_dmem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cpu_req_i, cpu_we_i, dbg_req_i, dbg_we_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i, dbg_addr_i, dbg_wdata_i;
    logic [2:0]  cpu_mask_i, dbg_mask_i;
    logic        cpu_gnt_o, cpu_rvalid_o, dbg_gnt_o, dbg_rvalid_o;
    logic [31:0] cpu_rdata_o, dbg_rdata_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [2:0]  mem_mask_o;
    logic        mem_we_o, mem_re_o;

    always #5 clk_i = ~clk_i;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cpu_req_i    (cpu_req_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_mask_i   (cpu_mask_i),
        .cpu_gnt_o    (cpu_gnt_o),
        .cpu_rvalid_o (cpu_rvalid_o),
        .cpu_rdata_o  (cpu_rdata_o),
        .dbg_req_i    (dbg_req_i),
        .dbg_we_i     (dbg_we_i),
        .dbg_addr_i   (dbg_addr_i),
        .dbg_wdata_i  (dbg_wdata_i),
        .dbg_mask_i   (dbg_mask_i),
        .dbg_gnt_o    (dbg_gnt_o),
        .dbg_rvalid_o (dbg_rvalid_o),
        .dbg_rdata_o  (dbg_rdata_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_mask_o   (mem_mask_o),
        .mem_we_o     (mem_we_o),
        .mem_re_o     (mem_re_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    typedef struct packed {
        logic        owner;   // 0 = CPU, 1 = DBG
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          m_starve = 0;
    logic [31:0] next_rdata = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Memory contents model: 0x10 holds 0xDEADBEEF, other words derive from the address.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic drive_cpu(input logic req, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [2:0] mask);
        cpu_req_i = req; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wdata; cpu_mask_i = mask;
    endtask

    task automatic drive_dbg(input logic req, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [2:0] mask);
        dbg_req_i = req; dbg_we_i = we; dbg_addr_i = addr; dbg_wdata_i = wdata; dbg_mask_i = mask;
    endtask

    // One clock cycle: inputs are already driven (just after a rising edge).
    task automatic tick(input logic exp_c, input logic exp_d, input string tag);
        logic        e_we, e_re, e_cv, e_dv;
        logic [31:0] e_addr, e_wdata, e_cd, e_dd;
        logic [2:0]  e_mask;
        rsp_t        r;
        mem_rdata_i = next_rdata;
        @(negedge clk_i);
        check({tag, " cpu_gnt"}, 32'(cpu_gnt_o), 32'(exp_c));
        check({tag, " dbg_gnt"}, 32'(dbg_gnt_o), 32'(exp_d));
        e_we = 1'b0; e_re = 1'b0; e_addr = '0; e_wdata = '0; e_mask = '0;
        if (exp_c) begin
            e_we = cpu_we_i; e_re = !cpu_we_i; e_addr = cpu_addr_i; e_wdata = cpu_wdata_i; e_mask = cpu_mask_i;
        end else if (exp_d) begin
            e_we = dbg_we_i; e_re = !dbg_we_i; e_addr = dbg_addr_i; e_wdata = dbg_wdata_i; e_mask = dbg_mask_i;
        end
        check({tag, " mem_we"},    32'(mem_we_o),    32'(e_we));
        check({tag, " mem_re"},    32'(mem_re_o),    32'(e_re));
        check({tag, " mem_addr"},  mem_addr_o,       e_addr);
        check({tag, " mem_wdata"}, mem_wdata_o,      e_wdata);
        check({tag, " mem_mask"},  32'(mem_mask_o),  32'(e_mask));
        e_cv = 1'b0; e_dv = 1'b0; e_cd = '0; e_dd = '0;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            e_cv = !r.owner; e_dv = r.owner;
            e_cd = r.owner ? 32'h0 : r.data;
            e_dd = r.owner ? r.data : 32'h0;
        end
        check({tag, " cpu_rvalid"}, 32'(cpu_rvalid_o), 32'(e_cv));
        check({tag, " dbg_rvalid"}, 32'(dbg_rvalid_o), 32'(e_dv));
        check({tag, " cpu_rdata"},  cpu_rdata_o,       e_cd);
        check({tag, " dbg_rdata"},  dbg_rdata_o,       e_dd);
        if (e_re) begin
            sb.push_back('{owner: exp_d && !exp_c, data: mem_model(e_addr)});
            next_rdata = mem_model(e_addr);
        end else begin
            next_rdata = 32'hBAD0_0000 | 32'(cyc);
        end
        if (!dbg_req_i || exp_d) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        @(posedge clk_i);
        #1;
        check({tag, " starve_cnt"}, 32'(dut.starve_cnt_q), 32'(m_starve));
        cyc++;
    endtask

    task automatic idle(input string tag);
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        drive_dbg(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick(1'b0, 1'b0, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic c, d, ec, ed;
        // Reset with both ports requesting: nothing may be granted.
        rst_ni = 1'b0;
        drive_cpu(1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
        drive_dbg(1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
        mem_rdata_i = 32'h0;
        #12;
        check("rst cpu_gnt",    32'(cpu_gnt_o),    32'h0);
        check("rst dbg_gnt",    32'(dbg_gnt_o),    32'h0);
        check("rst mem_re",     32'(mem_re_o),     32'h0);
        check("rst mem_we",     32'(mem_we_o),     32'h0);
        check("rst cpu_rvalid", 32'(cpu_rvalid_o), 32'h0);
        check("rst dbg_rvalid", 32'(dbg_rvalid_o), 32'h0);
        check("rst starve_cnt", 32'(dut.starve_cnt_q), 32'h0);
        check("rst state",      32'(dut.state_q),  32'h0);
        drive_dbg(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        #1;
        check("pre_edge cpu_gnt", 32'(cpu_gnt_o), 32'h0);
        check("pre_edge mem_re",  32'(mem_re_o),  32'h0);
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        @(posedge clk_i); #1;

        // CPU load from 0x10 alone, then its response.
        drive_cpu(1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
        tick(1'b1, 1'b0, "cpu_ld");
        idle("cpu_ld_rsp");

        // Debug store: write strobe, no read, no response.
        drive_dbg(1'b1, 1'b1, 32'h2000, 32'h1234_5678, 3'b010);
        tick(1'b0, 1'b1, "dbg_st");
        idle("dbg_st_rsp");

        // CPU load then debug load: responses must not swap.
        drive_cpu(1'b1, 1'b0, 32'h100, 32'h0, 3'b001);
        tick(1'b1, 1'b0, "swap_c");
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        drive_dbg(1'b1, 1'b0, 32'h200, 32'h0, 3'b101);
        tick(1'b0, 1'b1, "swap_d");
        idle("swap_rsp");

        // Both ports requesting continuously: forced debug grant on cycle 4.
        drive_dbg(1'b1, 1'b0, 32'h3000, 32'h0, 3'b100);
        for (int k = 0; k < 6; k++) begin
            drive_cpu(1'b1, 1'b0, 32'h1000 + 32'(k * 4), 32'h0, 3'b010);
            tick(k != 4, k == 4, "starve");
            if (k == 4) check("starve_clr", 32'(dut.starve_cnt_q), 32'h0);
        end
        idle("starve_rsp");

        // Debug waits three cycles then gives up: count 3 then 0, never granted.
        drive_dbg(1'b1, 1'b1, 32'h4000, 32'hCAFE_0000, 3'b010);
        for (int k = 0; k < 3; k++) begin
            drive_cpu(1'b1, 1'b0, 32'h500 + 32'(k * 4), 32'h0, 3'b010);
            tick(1'b1, 1'b0, "giveup");
        end
        check("giveup cnt3", 32'(dut.starve_cnt_q), 32'h3);
        drive_dbg(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        drive_cpu(1'b1, 1'b1, 32'h600, 32'h0BAD_F00D, 3'b010);
        tick(1'b1, 1'b0, "giveup_drop");
        check("giveup cnt0", 32'(dut.starve_cnt_q), 32'h0);
        idle("giveup_rsp");

        // Reset mid-cycle after a granted CPU load: outputs drop, response discarded.
        drive_cpu(1'b1, 1'b0, 32'h40, 32'h0, 3'b010);
        mem_rdata_i = next_rdata;
        @(negedge clk_i);
        check("mrst pre cpu_gnt", 32'(cpu_gnt_o), 32'h1);
        check("mrst pre mem_re",  32'(mem_re_o),  32'h1);
        #2 rst_ni = 1'b0;
        #1;
        check("mrst cpu_gnt",  32'(cpu_gnt_o),  32'h0);
        check("mrst mem_re",   32'(mem_re_o),   32'h0);
        check("mrst mem_addr", mem_addr_o,      32'h0);
        sb.delete();
        m_starve = 0;
        @(posedge clk_i); #1;
        check("mrst edge cpu_rvalid", 32'(cpu_rvalid_o), 32'h0);
        check("mrst edge cpu_gnt",    32'(cpu_gnt_o),    32'h0);
        rst_ni = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
        #1;
        check("mrst rel cpu_gnt", 32'(cpu_gnt_o), 32'h0);
        @(negedge clk_i);
        check("mrst rel cpu_rvalid", 32'(cpu_rvalid_o), 32'h0);
        check("mrst rel cpu_gnt2",   32'(cpu_gnt_o),    32'h0);
        @(posedge clk_i); #1;
        next_rdata = 32'hBAD0_1111;
        tick(1'b1, 1'b0, "post_rst");
        idle("post_rst_rsp");

        // Random traffic checked against a priority/starvation model.
        for (int i = 0; i < 60; i++) begin
            c = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            drive_cpu(c, ($urandom_range(0, 2) == 0), $urandom, $urandom, 3'($urandom));
            drive_dbg(d, ($urandom_range(0, 2) == 0), $urandom, $urandom, 3'($urandom));
            ed = d && (!c || (m_starve == LIMIT));
            ec = c && !ed;
            tick(ec, ed, "rnd");
        end
        idle("rnd_rsp");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, giving the number of consecutive stalled debug-port cycles before the debug port is force-granted (legal range 1..15).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports cpu_req_i / dbg_req_i  input  1  access request, level, held until granted.
REQ-005 SHALL have ports cpu_we_i / dbg_we_i  input  1  1 = store, 0 = load.
REQ-006 SHALL have ports cpu_addr_i / dbg_addr_i  input  32  byte address.
REQ-007 SHALL have ports cpu_wdata_i / dbg_wdata_i  input  32  store data.
REQ-008 SHALL have ports cpu_mask_i / dbg_mask_i  input  3  size/sign code, passed through unchanged.
REQ-009 SHALL have ports cpu_gnt_o / dbg_gnt_o  output  1  request accepted this cycle.
REQ-010 SHALL have ports cpu_rvalid_o / dbg_rvalid_o  output  1  load data valid this cycle.
REQ-011 SHALL have ports cpu_rdata_o / dbg_rdata_o  output  32  load data, valid only with matching rvalid.
REQ-012 SHALL have ports mem_addr_o (32), mem_wdata_o (32), mem_mask_o (3), mem_we_o (1), mem_re_o (1)  output  drive the shared memory port.
REQ-013 SHALL have port mem_rdata_i  input  32  memory load data, valid one cycle after mem_re_o.

Function
REQ-014 SHALL grant at most one requester per cycle; the grant is combinational in the same cycle as the request.
REQ-015 SHALL give the CPU priority by default; dbg_gnt_o asserts when dbg_req_i=1 and either cpu_req_i=0 or starve_cnt==STARVE_LIMIT.
REQ-016 SHALL keep a 4-bit starve_cnt that increments each cycle dbg_req_i=1 and dbg_gnt_o=0, clears on dbg_gnt_o=1 or dbg_req_i=0, and saturates at STARVE_LIMIT.
REQ-017 SHALL use a 3-state FSM {IDLE, OWN_CPU, OWN_DBG} recording the current-cycle grant; next state is OWN_CPU on cpu_gnt_o, OWN_DBG on dbg_gnt_o, otherwise IDLE.
REQ-018 SHALL drive the mem_* outputs from the granted requester; with no grant, mem_we_o=mem_re_o=0 and addr/wdata/mask=0.
REQ-019 SHALL set mem_re_o = grant & ~we and mem_we_o = grant & we, so both are never high together.
REQ-020 SHALL register the owner of each issued load (resp_valid, resp_owner) and, in the following cycle, assert exactly that owner's rvalid with rdata = mem_rdata_i; the non-owner's rdata SHALL be 0.
REQ-021 SHALL produce no rvalid for a store.
REQ-022 SHALL sustain back-to-back loads, one per cycle from either port, with in-order responses and a fixed 1-cycle latency.
REQ-023 SHALL handle a load granted to one port while the previous response returns to the other port without loss or misrouting.
REQ-024 SHALL, after a forced debug grant, re-apply CPU priority in the next cycle.

Reset
REQ-025 SHALL, while rst_ni=0, hold state=IDLE, starve_cnt=0, resp_valid=0, and all gnt/rvalid/mem_we_o/mem_re_o outputs at 0, independent of the clock.
REQ-026 SHALL discard a load response pending when reset asserts; no rvalid is produced after reset deasserts.
REQ-027 SHALL issue no grant before the first rising edge following rst_ni deassertion.

Structure
REQ-028 SHALL take the FSM state encoding and owner encoding (OWN_CPU=0, OWN_DBG=1) from the shared rv32i defines package, not define them locally.
REQ-029 SHALL be one module; the only natural sub-module is dmem_rsp_tracker, which holds resp_valid and resp_owner and performs rvalid/rdata routing.
REQ-030 SHALL contain no memory array and no combinational path from mem_rdata_i to any mem_* output.

Verification
REQ-031 SHALL cover: CPU load addr 0x10 alone -> cpu_gnt_o same cycle, mem_re_o=1, next cycle cpu_rvalid_o=1 with mem_rdata_i value 0xDEADBEEF, dbg_rvalid_o=0.
REQ-032 SHALL cover: CPU and DBG requesting continuously, STARVE_LIMIT=4 -> CPU granted cycles 0-3, DBG granted cycle 4, CPU granted cycle 5, starve_cnt=0 after cycle 4.
REQ-033 SHALL cover: CPU load at cycle 0, DBG load at cycle 1 (CPU idle) -> cpu_rvalid_o at cycle 1, dbg_rvalid_o at cycle 2, data not swapped.
REQ-034 SHALL cover: DBG store 0x12345678 to 0x2000 -> mem_we_o=1, mem_re_o=0, mem_wdata_o=0x12345678, and no rvalid the following cycle.
REQ-035 SHALL cover: rst_ni asserted mid-cycle after a granted CPU load -> outputs zero immediately, and no cpu_rvalid_o after release.
REQ-036 SHALL cover: DBG requests for 3 cycles then drops -> starve_cnt reaches 3 then clears to 0, and no DBG grant is issued.
